gate_sweep_checker: RTL and testbench

GATE_SWEEP_CHECKER -- requirements
Module: gate_sweep_checker

---
 rtl/gate_sweep_checker.sv | 141 ++++++++++++++
 tb/tb_gate_sweep_checker.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/gate_sweep_checker.sv
// rtl/gate_sweep_checker.sv - exhaustive two-input sweep checker for an AND/OR/NOR/XOR gate array
//
// Purpose:
//   Drives the four operand combinations {a,b} = 00, 01, 10, 11 onto a gate
//   array. Each combination is held for SETTLE cycles. At the last cycle of
//   each hold, the array result o_in is compared against the ideal response.
//   The checker accumulates a per-bit mismatch mask, a count of failing
//   vectors and the index of the first failing vector. It then reports
//   pass/done.
//
// Parameters:
//   SETTLE       cycles each vector is held before o_in is sampled (1..15)
//   STOP_ON_FAIL 1 = end the sweep at the first mismatching vector
//
// Ports:
//   clk        in   sole clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   one-cycle sweep request (ignored while busy)
//   o_in[3:0]  in   array result: [0] AND, [1] OR, [2] NOR, [3] XOR of (a,b)
//   a, b       out  registered stimulus operands
//   busy       out  sweep in progress
//   done       out  one-cycle pulse at sweep end
//   pass       out  last sweep had no mismatches (held until next start)
//   fail_mask  out  OR of per-bit mismatches over the last sweep
//   err_count  out  number of mismatching vectors in the last sweep (0..4)
//   first_fail out  {a,b} of the first mismatching vector, 0 when passing

module gate_sweep_checker #(
  parameter int unsigned SETTLE       = 1,
  parameter bit          STOP_ON_FAIL = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] o_in,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_mask,
  output logic [2:0] err_count,
  output logic [1:0] first_fail
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // The counter holds the number of remaining wait cycles. A value of SETTLE-1
  // gives exactly SETTLE cycles per vector, because the sample edge is the one
  // where the counter reads 0.
  localparam logic [3:0] RELOAD = 4'(SETTLE - 1);

  state_e     state_q;
  logic [1:0] vec_q;
  logic [3:0] cnt_q;
  logic       done_q;
  logic       pass_q;
  logic [3:0] fail_mask_q;
  logic [2:0] err_count_q;
  logic [1:0] first_fail_q;

  logic [3:0] exp_d;
  logic [3:0] diff_d;
  logic       mismatch_d;
  logic       final_d;

  // The ideal response is derived from the registered operands, so it always
  // matches what the array is currently seeing.
  always_comb begin
    exp_d      = {vec_q[1] ^ vec_q[0], ~(vec_q[1] | vec_q[0]),
                  vec_q[1] | vec_q[0], vec_q[1] & vec_q[0]};
    diff_d     = o_in ^ exp_d;
    mismatch_d = |diff_d;
    final_d    = (vec_q == 2'b11) || (STOP_ON_FAIL && mismatch_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      vec_q        <= 2'b00;
      cnt_q        <= 4'd0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      fail_mask_q  <= 4'd0;
      err_count_q  <= 3'd0;
      first_fail_q <= 2'b00;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q      <= RUN;
            vec_q        <= 2'b00;
            cnt_q        <= RELOAD;
            pass_q       <= 1'b0;
            fail_mask_q  <= 4'd0;
            err_count_q  <= 3'd0;
            first_fail_q <= 2'b00;
          end
        end
        RUN: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            fail_mask_q <= fail_mask_q | diff_d;
            if (mismatch_d) begin
              err_count_q <= err_count_q + 3'd1;
              // A zero error count means that no earlier vector in this sweep failed.
              if (err_count_q == 3'd0) begin
                first_fail_q <= vec_q;
              end
            end
            if (final_d) begin
              // The operands keep their last values, so a failing vector stays visible.
              state_q <= IDLE;
              done_q  <= 1'b1;
              pass_q  <= (err_count_q == 3'd0) && !mismatch_d;
            end else begin
              vec_q <= vec_q + 2'b01;
              cnt_q <= RELOAD;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign a          = vec_q[1];
  assign b          = vec_q[0];
  assign busy       = (state_q == RUN);
  assign done       = done_q;
  assign pass       = pass_q;
  assign fail_mask  = fail_mask_q;
  assign err_count  = err_count_q;
  assign first_fail = first_fail_q;

endmodule

// File: tb/tb_gate_sweep_checker.sv
// tb/tb_gate_sweep_checker.sv - directed self-checking bench for gate_sweep_checker
//
// Purpose:
//   This bench drives three instances of the checker:
//     u1 : SETTLE=1, STOP_ON_FAIL=0
//     u3 : SETTLE=3, STOP_ON_FAIL=0
//     us : SETTLE=1, STOP_ON_FAIL=1
//   Each instance faces a behavioural gate array. Individual result bits of
//   that array can be forced to 0 or to 1.
//   Inputs are driven and outputs are sampled on the falling clock edge.

module tb_gate_sweep_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic       start1 = 1'b0, start3 = 1'b0, starts = 1'b0;
  logic [3:0] s0_1 = 4'd0, s1_1 = 4'd0;
  logic [3:0] s0_3 = 4'd0, s1_3 = 4'd0;
  logic [3:0] s0_s = 4'd0, s1_s = 4'd0;

  logic [3:0] o_in1, o_in3, o_ins;
  logic       a1, b1, busy1, done1, pass1;
  logic       a3, b3, busy3, done3, pass3;
  logic       as_, bs, busys, dones, passs;
  logic [3:0] fm1, fm3, fms;
  logic [2:0] ec1, ec3, ecs;
  logic [1:0] ff1, ff3, ffs;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Each behavioural gate array is modelled per output bit. The s0 mask forces
  // the selected bits to 0, and the s1 mask forces them to 1.
  assign o_in1 = ({a1 ^ b1, ~(a1 | b1), a1 | b1, a1 & b1} & ~s0_1) | s1_1;
  assign o_in3 = ({a3 ^ b3, ~(a3 | b3), a3 | b3, a3 & b3} & ~s0_3) | s1_3;
  assign o_ins = ({as_ ^ bs, ~(as_ | bs), as_ | bs, as_ & bs} & ~s0_s) | s1_s;

  gate_sweep_checker #(.SETTLE(1), .STOP_ON_FAIL(1'b0)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .o_in(o_in1),
    .a(a1), .b(b1), .busy(busy1), .done(done1), .pass(pass1),
    .fail_mask(fm1), .err_count(ec1), .first_fail(ff1)
  );

  gate_sweep_checker #(.SETTLE(3), .STOP_ON_FAIL(1'b0)) u3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .o_in(o_in3),
    .a(a3), .b(b3), .busy(busy3), .done(done3), .pass(pass3),
    .fail_mask(fm3), .err_count(ec3), .first_fail(ff3)
  );

  gate_sweep_checker #(.SETTLE(1), .STOP_ON_FAIL(1'b1)) us (
    .clk(clk), .rst_n(rst_n), .start(starts), .o_in(o_ins),
    .a(as_), .b(bs), .busy(busys), .done(dones), .pass(passs),
    .fail_mask(fms), .err_count(ecs), .first_fail(ffs)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_u1_all_zero(input string tag);
    chk({tag, "_ab"},   32'({a1, b1}), 0);
    chk({tag, "_busy"}, 32'(busy1), 0);
    chk({tag, "_done"}, 32'(done1), 0);
    chk({tag, "_pass"}, 32'(pass1), 0);
    chk({tag, "_fm"},   32'(fm1), 0);
    chk({tag, "_ec"},   32'(ec1), 0);
    chk({tag, "_ff"},   32'(ff1), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk_u1_all_zero("rst");
    chk("rst_busy3", 32'(busy3), 0);
    chk("rst_busys", 32'(busys), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", 32'(busy1), 0);

    // Sweep on u1 with XOR output stuck at 0. A second start at edge 2 must be ignored.
    s0_1   = 4'b1000;
    start1 = 1'b1;
    @(negedge clk);                        // after edge 0
    start1 = 1'b0;
    chk("a_e0_busy", 32'(busy1), 1);
    chk("a_e0_ab",   32'({a1, b1}), 0);
    @(negedge clk);                        // after edge 1
    chk("a_e1_ab", 32'({a1, b1}), 1);
    chk("a_e1_ec", 32'(ec1), 0);
    start1 = 1'b1;                         // seen at edge 2 while running
    @(negedge clk);                        // after edge 2
    start1 = 1'b0;
    chk("a_e2_ab", 32'({a1, b1}), 2);
    chk("a_e2_ec", 32'(ec1), 1);
    chk("a_e2_ff", 32'(ff1), 1);
    @(negedge clk);                        // after edge 3
    chk("a_e3_ab",   32'({a1, b1}), 3);
    chk("a_e3_ec",   32'(ec1), 2);
    chk("a_e3_done", 32'(done1), 0);
    chk("a_e3_busy", 32'(busy1), 1);
    @(negedge clk);                        // after edge 4
    chk("a_e4_done", 32'(done1), 1);
    chk("a_e4_busy", 32'(busy1), 0);
    chk("a_e4_pass", 32'(pass1), 0);
    chk("a_e4_fm",   32'(fm1), 8);
    chk("a_e4_ec",   32'(ec1), 2);
    chk("a_e4_ff",   32'(ff1), 1);
    chk("a_e4_ab",   32'({a1, b1}), 3);

    // A start at the edge right after done is accepted, and the results clear.
    s0_1   = 4'b0000;
    start1 = 1'b1;
    @(negedge clk);                        // after edge 5
    start1 = 1'b0;
    chk("b_e5_done", 32'(done1), 0);
    chk("b_e5_busy", 32'(busy1), 1);
    chk("b_e5_ab",   32'({a1, b1}), 0);
    chk("b_e5_fm",   32'(fm1), 0);
    chk("b_e5_ec",   32'(ec1), 0);
    chk("b_e5_ff",   32'(ff1), 0);
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      chk("b_ab",   32'({a1, b1}), 32'(i));
      chk("b_busy", 32'(busy1), 1);
    end
    @(negedge clk);
    chk("b_done", 32'(done1), 1);
    chk("b_pass", 32'(pass1), 1);
    chk("b_fm",   32'(fm1), 0);
    chk("b_ec",   32'(ec1), 0);
    chk("b_busy_end", 32'(busy1), 0);
    @(negedge clk);
    chk("b_done_pulse", 32'(done1), 0);
    chk("b_pass_hold",  32'(pass1), 1);
    chk("b_ab_hold",    32'({a1, b1}), 3);

    // SETTLE=3 on u3: each vector is held for three cycles, and done follows edge 12.
    start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    for (int i = 0; i < 12; i++) begin
      chk("c_ab",   32'({a3, b3}), 32'(i / 3));
      chk("c_busy", 32'(busy3), 1);
      chk("c_done", 32'(done3), 0);
      @(negedge clk);
    end
    chk("c_done_end", 32'(done3), 1);
    chk("c_busy_end", 32'(busy3), 0);
    chk("c_pass",     32'(pass3), 1);
    chk("c_fm",       32'(fm3), 0);
    chk("c_ec",       32'(ec3), 0);

    // STOP_ON_FAIL on us with NOR output stuck at 1: the sweep ends at vector 01.
    s1_s   = 4'b0100;
    starts = 1'b1;
    @(negedge clk);                        // after edge 0
    starts = 1'b0;
    chk("d_e0_ab", 32'({as_, bs}), 0);
    @(negedge clk);                        // after edge 1
    chk("d_e1_ab",   32'({as_, bs}), 1);
    chk("d_e1_busy", 32'(busys), 1);
    chk("d_e1_done", 32'(dones), 0);
    @(negedge clk);                        // after edge 2
    chk("d_e2_done", 32'(dones), 1);
    chk("d_e2_busy", 32'(busys), 0);
    chk("d_e2_pass", 32'(passs), 0);
    chk("d_e2_fm",   32'(fms), 4);
    chk("d_e2_ec",   32'(ecs), 1);
    chk("d_e2_ff",   32'(ffs), 1);
    chk("d_e2_ab",   32'({as_, bs}), 1);
    @(negedge clk);
    chk("d_done_pulse", 32'(dones), 0);

    // Reset in the middle of a sweep on u1: outputs clear at once and no done pulse appears.
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    @(negedge clk);
    @(posedge clk);                        // edge 2
    #2 rst_n = 1'b0;
    #1 chk_u1_all_zero("e_async");
    repeat (2) begin
      @(negedge clk);
      chk("e_hold_done", 32'(done1), 0);
      chk("e_hold_busy", 32'(busy1), 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk_u1_all_zero("e_idle");
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    chk("e_busy", 32'(busy1), 1);
    repeat (3) @(negedge clk);
    chk("e_ab3", 32'({a1, b1}), 3);
    @(negedge clk);
    chk("e_done", 32'(done1), 1);
    chk("e_pass", 32'(pass1), 1);
    chk("e_ec",   32'(ec1), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
